mc_control: RTL and testbench
=============================

# mc_control

Multicycle MIPS control unit. A registered Moore state machine steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and enable, including the 2-bit `reg_dst` select of the downstream 3:1 write-register mux (rt / rd / 31). It also handles memory wait states and counts retired instructions.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter.

Ports, all outputs active-high unless noted:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: `IR[31:26]`, stable from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if ALU zero.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `ir_write` out 1: IR load.
- `reg_dst` out 2: write-register mux select, 00 = rt, 01 = rd, 10 = 31, 11 never driven.
- `mem_to_reg` out 2: write-data select, 00 = ALUOut, 01 = MDR, 10 = PC.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: ALU A select, 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU B select, 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct.
- `pc_source` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: unrecognised opcode in DECODE.
- `state` out 4: current state, for debug.
- `retired` out `CNT_W`: retired-instruction count.

## Operation
Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, JAL = 000011, ADDI = 001000.

Transitions:
- FETCH → DECODE on `mem_ready`; otherwise stay in FETCH.
- DECODE → EXECUTE (R), MEM_ADDR (LW/SW), BRANCH, JUMP, JAL or ADDI_EX; any other opcode → FETCH.
- EXECUTE → ALU_WB.
- MEM_ADDR → MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ → MEM_WB on `mem_ready`; otherwise stay.
- MEM_WRITE → FETCH on `mem_ready`; otherwise stay.
- ADDI_EX → ADDI_WB.
- ALU_WB, MEM_WB, BRANCH, JUMP, JAL, ADDI_WB → FETCH.

Outputs per state; any output not listed is 0:
- FETCH: `mem_read` = 1, `alu_src_b` = 01. `ir_write` = `pc_write` = `mem_ready` (the only Mealy terms).
- DECODE: `alu_src_b` = 11; `illegal_op` = 1 when the opcode is not in the set above.
- MEM_ADDR and ADDI_EX: `alu_src_a` = 1, `alu_src_b` = 10.
- MEM_READ: `mem_read` = 1, `iord` = 1.
- MEM_WRITE: `mem_write` = 1, `iord` = 1.
- MEM_WB: `reg_write` = 1, `reg_dst` = 00, `mem_to_reg` = 01.
- EXECUTE: `alu_src_a` = 1, `alu_op` = 10.
- ALU_WB: `reg_write` = 1, `reg_dst` = 01.
- BRANCH: `alu_src_a` = 1, `alu_op` = 01, `pc_write_cond` = 1, `pc_source` = 01.
- JUMP: `pc_write` = 1, `pc_source` = 10.
- JAL: `pc_write` = 1, `pc_source` = 10, `reg_write` = 1, `reg_dst` = 10, `mem_to_reg` = 10.
- ADDI_WB: `reg_write` = 1, `reg_dst` = 00.

Retired counter:
- `retired` increments by 1 on each clock edge that leaves a terminal state for FETCH. Terminal states: ALU_WB, MEM_WB, MEM_WRITE (with `mem_ready`), BRANCH, JUMP, JAL, ADDI_WB.
- An illegal opcode is not counted.
- The counter wraps modulo 2^`CNT_W`.

## Timing
- `rst` asserted at any time, including mid-instruction or mid-wait, immediately forces:
  - state = FETCH;
  - `retired` = 0;
  - all outputs to their FETCH values, with `ir_write`/`pc_write` following `mem_ready`;
  - `illegal_op` = 0.
- Cycles per instruction with `mem_ready` held high: R 4, LW 5, SW 4, BEQ 3, J 3, JAL 3, ADDI 4, illegal 2. Each cycle of low `mem_ready` in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- During a wait, outputs hold their values.
- `reg_dst` is valid throughout every `reg_write` cycle and holds 00 in all non-write states.
- `illegal_op` is high for exactly one cycle per illegal instruction.

## Structure
- Shared package `mc_pkg`: the 4-bit state encodings (FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, EXECUTE = 6, ALU_WB = 7, BRANCH = 8, JUMP = 9, JAL = 10, ADDI_EX = 11, ADDI_WB = 12), the opcode constants, and the `reg_dst`/`mem_to_reg`/`alu_src_b`/`pc_source` codes.
- One sub-module, `mc_retire_cnt`: the wrapping counter with increment enable and async clear.

## Test plan
- Reset mid-LW while in MEM_READ → the next sample shows state = 0, `retired` = 0, `mem_read` = 1, `reg_write` = 0.
- R-type `add` with `mem_ready` = 1 → states 0, 1, 6, 7. ALU_WB shows `reg_dst` = 01 and `reg_write` = 1; `retired` goes 0 → 1.
- JAL → states 0, 1, 10. JAL shows `reg_dst` = 10, `mem_to_reg` = 10, `pc_write` = 1 and `pc_source` = 10.
- LW with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM_READ → 10 cycles total. `ir_write` pulses only on the ready cycle; MEM_WB shows `reg_dst` = 00 and `mem_to_reg` = 01.
- Opcode 111111 → `illegal_op` is high for 1 cycle in DECODE, the FSM returns to FETCH, and `retired` is unchanged.
- `CNT_W` = 4: 16 back-to-back J instructions → `retired` wraps to 0 after 48 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// and the datapath mux select codes.
package mc_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_ALU_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_ADDI_EX   = 4'd11;
    localparam logic [3:0] S_ADDI_WB   = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    localparam logic [1:0] SB_B     = 2'b00;
    localparam logic [1:0] SB_FOUR  = 2'b01;
    localparam logic [1:0] SB_IMM   = 2'b10;
    localparam logic [1:0] SB_IMMSH = 2'b11;

    localparam logic [1:0] AO_ADD   = 2'b00;
    localparam logic [1:0] AO_SUB   = 2'b01;
    localparam logic [1:0] AO_FUNCT = 2'b10;

    localparam logic [1:0] PS_ALU    = 2'b00;
    localparam logic [1:0] PS_ALUOUT = 2'b01;
    localparam logic [1:0] PS_JUMP   = 2'b10;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_J) || (op == OP_JAL) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_retire_cnt.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, cleared asynchronously.
module mc_retire_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_reg <= '0;
        else if (inc)
            count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign count = count_reg;

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: Moore outputs per state, except ir_write and
// pc_write in FETCH, which follow mem_ready so the PC/IR load on the ready cycle.
module mc_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       retire_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:     if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:            state_next = S_EXECUTE;
                    OP_LW, OP_SW:    state_next = S_MEM_ADDR;
                    OP_BEQ:          state_next = S_BRANCH;
                    OP_J:            state_next = S_JUMP;
                    OP_JAL:          state_next = S_JAL;
                    OP_ADDI:         state_next = S_ADDI_EX;
                    default:         state_next = S_FETCH;
                endcase
            end
            S_EXECUTE:   state_next = S_ALU_WB;
            S_MEM_ADDR:  state_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
            S_ADDI_EX:   state_next = S_ADDI_WB;
            default:     state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = RD_RT;
        mem_to_reg    = WD_ALUOUT;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SB_B;
        alu_op        = AO_ADD;
        pc_source     = PS_ALU;
        illegal_op    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SB_IMMSH;
                illegal_op = !is_legal(opcode);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WD_MDR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = AO_FUNCT;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = RD_RD;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = AO_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PS_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PS_JUMP;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PS_JUMP;
                reg_write  = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = WD_PC;
            end
            S_ADDI_WB:   reg_write = 1'b1;
            default: ;
        endcase
    end

    // An instruction retires on the edge that leaves its last state for FETCH;
    // the illegal-opcode path from DECODE deliberately does not count.
    always_comb begin
        case (state_reg)
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_ADDI_WB: retire_inc = 1'b1;
            S_MEM_WRITE: retire_inc = mem_ready;
            default:     retire_inc = 1'b0;
        endcase
    end

    mc_retire_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_inc),
        .count (retired)
    );

    assign state = state_reg;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a per-cycle vector table through every
// instruction type, plus reset-mid-wait and counter-wrap sequences.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic        reg_write, alu_src_a, illegal_op;
    logic [3:0]  state;
    logic [15:0] retired;

    logic        rst4;
    logic [5:0]  opcode4;
    logic        mem_ready4;
    logic        pc_write4, pc_write_cond4, iord4, mem_read4, mem_write4, ir_write4;
    logic [1:0]  reg_dst4, mem_to_reg4, alu_src_b4, alu_op4, pc_source4;
    logic        reg_write4, alu_src_a4, illegal_op4;
    logic [3:0]  state4;
    logic [3:0]  retired4;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mc_control #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
        .retired(retired)
    );

    mc_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .opcode(opcode4), .mem_ready(mem_ready4),
        .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .iord(iord4),
        .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
        .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .reg_write(reg_write4),
        .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
        .pc_source(pc_source4), .illegal_op(illegal_op4), .state(state4),
        .retired(retired4)
    );

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
    //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    logic [18:0] outs;
    assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, illegal_op};

    localparam logic [18:0] O_FETCH_R = {6'b100101, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] O_FETCH_W = {6'b000100, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] O_DECODE  = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] O_DEC_ILL = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [18:0] O_MADDR   = {6'b000000, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] O_MREAD   = {6'b001100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] O_MWRITE  = {6'b001010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] O_MWB     = {6'b000000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] O_EXEC    = {6'b000000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [18:0] O_ALUWB   = {6'b000000, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] O_BRANCH  = {6'b010000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [18:0] O_JUMP    = {6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [18:0] O_JAL     = {6'b100000, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [18:0] O_ADDIWB  = {6'b000000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0};

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] o;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[40];
    int   nvec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [18:0] o, input logic [15:0] ret);
        vecs[nvec] = '{op: op, rdy: rdy, st: st, o: o, ret: ret};
        nvec++;
    endtask

    initial begin
        nvec = 0;
        // R-type: 0,1,6,7
        add(R, 1, 0, O_FETCH_R, 0);  add(R, 1, 1, O_DECODE, 0);
        add(R, 1, 6, O_EXEC, 0);     add(R, 1, 7, O_ALUWB, 0);
        // JAL: 0,1,10
        add(JAL, 1, 0, O_FETCH_R, 1); add(JAL, 1, 1, O_DECODE, 1); add(JAL, 1, 10, O_JAL, 1);
        // LW, 2 wait cycles in FETCH, 3 in MEM_READ: 10 cycles
        add(LW, 0, 0, O_FETCH_W, 2); add(LW, 0, 0, O_FETCH_W, 2); add(LW, 1, 0, O_FETCH_R, 2);
        add(LW, 1, 1, O_DECODE, 2);  add(LW, 1, 2, O_MADDR, 2);
        add(LW, 0, 3, O_MREAD, 2);   add(LW, 0, 3, O_MREAD, 2);   add(LW, 0, 3, O_MREAD, 2);
        add(LW, 1, 3, O_MREAD, 2);   add(LW, 1, 4, O_MWB, 2);
        // SW with one wait in MEM_WRITE
        add(SW, 1, 0, O_FETCH_R, 3); add(SW, 1, 1, O_DECODE, 3); add(SW, 1, 2, O_MADDR, 3);
        add(SW, 0, 5, O_MWRITE, 3);  add(SW, 1, 5, O_MWRITE, 3);
        // illegal opcode: 2 cycles, not counted
        add(BAD, 1, 0, O_FETCH_R, 4); add(BAD, 1, 1, O_DEC_ILL, 4);
        // BEQ
        add(BEQ, 1, 0, O_FETCH_R, 4); add(BEQ, 1, 1, O_DECODE, 4); add(BEQ, 1, 8, O_BRANCH, 4);
        // ADDI
        add(ADDI, 1, 0, O_FETCH_R, 5); add(ADDI, 1, 1, O_DECODE, 5);
        add(ADDI, 1, 11, O_MADDR, 5);  add(ADDI, 1, 12, O_ADDIWB, 5);
        // J
        add(J, 1, 0, O_FETCH_R, 6); add(J, 1, 1, O_DECODE, 6); add(J, 1, 9, O_JUMP, 6);

        rst = 1'b1; opcode = R; mem_ready = 1'b1;
        rst4 = 1'b1; opcode4 = J; mem_ready4 = 1'b1;

        @(negedge clk); #1;
        $display("reset: state=%0d retired=%0d outs=%h", state, retired, outs);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_outs", 32'(outs), 32'(O_FETCH_R));
        rst = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            opcode = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #1;
            $display("vec %0d: op=%b rdy=%b state=%0d outs=%h retired=%0d",
                     i, opcode, mem_ready, state, outs, retired);
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].o));
            chk($sformatf("vec%0d_retired", i), 32'(retired), 32'(vecs[i].ret));
            @(negedge clk);
        end

        #1;
        $display("after table: state=%0d retired=%0d", state, retired);
        chk("end_state", 32'(state), 32'd0);
        chk("end_retired", 32'(retired), 32'd7);

        // Reset asserted mid-LW while waiting in MEM_READ
        opcode = LW; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk); #1;
        chk("midlw_in_memread", 32'(state), 32'd3);
        rst = 1'b1;
        #1;
        $display("reset mid-LW: state=%0d retired=%0d mem_read=%b reg_write=%b ir_write=%b",
                 state, retired, mem_read, reg_write, ir_write);
        chk("midlw_state", 32'(state), 32'd0);
        chk("midlw_retired", 32'(retired), 32'd0);
        chk("midlw_mem_read", 32'(mem_read), 32'd1);
        chk("midlw_reg_write", 32'(reg_write), 32'd0);
        chk("midlw_ir_write", 32'(ir_write), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // CNT_W = 4: 16 back-to-back J wrap the counter after 48 cycles
        #1;
        chk("wrap_start", 32'(retired4), 32'd0);
        rst4 = 1'b0;
        repeat (45) @(negedge clk);
        #1;
        $display("wrap: after 45 cycles state=%0d retired=%0d", state4, retired4);
        chk("wrap_45_retired", 32'(retired4), 32'd15);
        chk("wrap_45_state", 32'(state4), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("wrap_47_state", 32'(state4), 32'd9);
        chk("wrap_47_retired", 32'(retired4), 32'd15);
        @(negedge clk); #1;
        $display("wrap: after 48 cycles state=%0d retired=%0d", state4, retired4);
        chk("wrap_48_retired", 32'(retired4), 32'd0);
        chk("wrap_48_state", 32'(state4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
